// File: rtl/inst_cache_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
package inst_cache_pkg;

    typedef enum logic [1:0] {IDLE, REFILL, UPDATE} state_t;

    localparam int BLOCK_WORDS = 4;
    localparam int OFFSET_W    = 2;
    localparam int ADDR_W      = 32;
    localparam int WORD_W      = 32;

    function automatic int index_w(input int lines);
        return $clog2(lines);
    endfunction

    // Tag is whatever remains above index, word offset and byte offset.
    function automatic int tag_w(input int lines);
        return ADDR_W - $clog2(lines) - OFFSET_W - 2;
    endfunction

endpackage

// File: rtl/inst_cache_if.sv
// Fetch-side and refill-memory signals of the instruction cache, bundled as one bus.
interface inst_cache_if
    import inst_cache_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic [ADDR_W-1:0] inst_adr;
    logic [WORD_W-1:0] inst;
    logic              stall;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_adr;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_ready;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    modport master (
        output inst_adr, mem_rdata, mem_ready,
        input  inst, stall, mem_req, mem_adr, hit_count, miss_count
    );

    modport slave (
        input  inst_adr, mem_rdata, mem_ready,
        output inst, stall, mem_req, mem_adr, hit_count, miss_count
    );
endinterface

// File: rtl/icache_array.sv
// Tag/valid/data storage: combinational read of one line, whole-line synchronous write.
module icache_array
    import inst_cache_pkg::*;
#(
    parameter int LINES = 32,
    parameter int IDX_W = index_w(LINES),
    parameter int TAG_W = tag_w(LINES)
)
(
    input  logic                                clk,
    input  logic                                rst,
    input  logic [IDX_W-1:0]                    rd_index,
    output logic                                rd_valid,
    output logic [TAG_W-1:0]                    rd_tag,
    output logic [BLOCK_WORDS-1:0][WORD_W-1:0]  rd_data,
    input  logic                                wr_en,
    input  logic [IDX_W-1:0]                    wr_index,
    input  logic [TAG_W-1:0]                    wr_tag,
    input  logic [BLOCK_WORDS-1:0][WORD_W-1:0]  wr_data
);
    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] valid_d;
    logic [TAG_W-1:0] tag_mem_q [LINES];

    always_comb begin
        valid_d = valid_q;
        if (wr_en) begin
            valid_d[wr_index] = 1'b1;
        end
    end

    // Only valid bits are cleared; stale tags/data are harmless behind valid=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem_q[wr_index] <= wr_tag;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BLOCK_WORDS; gi++) begin : g_word
            logic [WORD_W-1:0] word_mem_q [LINES];

            always_ff @(posedge clk) begin
                if (wr_en) begin
                    word_mem_q[wr_index] <= wr_data[gi];
                end
            end

            assign rd_data[gi] = word_mem_q[rd_index];
        end
    endgenerate

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem_q[rd_index];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache: zero-latency hits, 4-beat in-order block refill.
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int LINES = 32,
    parameter int CNT_W = 16
)
(
    input  logic          clk,
    input  logic          rst,
    inst_cache_if.slave   bus
);
    localparam int IDX_W   = index_w(LINES);
    localparam int TAG_W   = tag_w(LINES);
    localparam int IDX_LSB = OFFSET_W + 2;
    localparam logic [CNT_W-1:0]    CNT_MAX   = '1;
    localparam logic [OFFSET_W-1:0] LAST_BEAT = OFFSET_W'(BLOCK_WORDS - 1);

    state_t                               state_q, state_d;
    logic [TAG_W-1:0]                     tag_q, tag_d;
    logic [IDX_W-1:0]                     idx_q, idx_d;
    logic [OFFSET_W-1:0]                  beat_q, beat_d;
    logic [BLOCK_WORDS-1:0][WORD_W-1:0]   buf_q, buf_d;
    logic                                 mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]                    mem_adr_q, mem_adr_d;
    logic [CNT_W-1:0]                     hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]                     miss_cnt_q, miss_cnt_d;

    logic [TAG_W-1:0]                     fetch_tag;
    logic [IDX_W-1:0]                     fetch_idx;
    logic [OFFSET_W-1:0]                  fetch_off;
    logic [1:0]                           unused_byte_off;

    logic                                 rd_valid;
    logic [TAG_W-1:0]                     rd_tag;
    logic [BLOCK_WORDS-1:0][WORD_W-1:0]   rd_data;
    logic                                 hit;
    logic                                 wr_en;

    assign fetch_tag       = bus.inst_adr[ADDR_W-1:IDX_LSB+IDX_W];
    assign fetch_idx       = bus.inst_adr[IDX_LSB+IDX_W-1:IDX_LSB];
    assign fetch_off       = bus.inst_adr[IDX_LSB-1:2];
    assign unused_byte_off = bus.inst_adr[1:0];

    icache_array #(
        .LINES (LINES)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_index (fetch_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_index (idx_q),
        .wr_tag   (tag_q),
        .wr_data  (buf_q)
    );

    assign hit   = (state_q == IDLE) && rd_valid && (rd_tag == fetch_tag);
    assign wr_en = (state_q == UPDATE);

    always_comb begin
        state_d    = state_q;
        tag_d      = tag_q;
        idx_d      = idx_q;
        beat_d     = beat_q;
        buf_d      = buf_q;
        mem_req_d  = mem_req_q;
        mem_adr_d  = mem_adr_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    if (hit_cnt_q != CNT_MAX) begin
                        hit_cnt_d = hit_cnt_q + 1'b1;
                    end
                end else begin
                    tag_d     = fetch_tag;
                    idx_d     = fetch_idx;
                    beat_d    = '0;
                    mem_req_d = 1'b1;
                    mem_adr_d = {fetch_tag, fetch_idx, {OFFSET_W{1'b0}}, 2'b00};
                    state_d   = REFILL;
                    if (miss_cnt_q != CNT_MAX) begin
                        miss_cnt_d = miss_cnt_q + 1'b1;
                    end
                end
            end
            REFILL: begin
                // mem_req/mem_adr only move on an accepted beat, so they hold during wait states.
                if (bus.mem_ready) begin
                    buf_d[beat_q] = bus.mem_rdata;
                    beat_d        = beat_q + 1'b1;
                    mem_adr_d     = {tag_q, idx_q, beat_d, 2'b00};
                    if (beat_q == LAST_BEAT) begin
                        mem_req_d = 1'b0;
                        state_d   = UPDATE;
                    end
                end
            end
            UPDATE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tag_q      <= '0;
            idx_q      <= '0;
            beat_q     <= '0;
            buf_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_adr_q  <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tag_q      <= tag_d;
            idx_q      <= idx_d;
            beat_q     <= beat_d;
            buf_q      <= buf_d;
            mem_req_q  <= mem_req_d;
            mem_adr_q  <= mem_adr_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign bus.inst       = rd_data[fetch_off];
    assign bus.stall      = !hit;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_adr    = mem_adr_q;
    assign bus.hit_count  = hit_cnt_q;
    assign bus.miss_count = miss_cnt_q;

endmodule

// File: tb/tb_inst_cache.sv
// Randomized bench for inst_cache against a line-level reference model; a 4-bit-counter copy checks saturation.
module tb_inst_cache;

    localparam int LINES = 32;
    localparam int LIMIT = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] adr = 32'h0;
    logic        ready = 1'b0;

    int tests  = 0;
    int errors = 0;

    // Reference model: per-line valid/tag plus expected counter values.
    bit          mv [LINES];
    int unsigned mt [LINES];
    int unsigned m_hits;
    int unsigned m_misses;

    inst_cache_if #(.CNT_W(16)) bus ();
    inst_cache_if #(.CNT_W(4))  bus_s ();

    always #5 clk = ~clk;

    assign bus.inst_adr    = adr;
    assign bus.mem_ready   = ready;
    assign bus.mem_rdata   = 32'h1000_0000 + bus.mem_adr;
    assign bus_s.inst_adr  = adr;
    assign bus_s.mem_ready = ready;
    assign bus_s.mem_rdata = 32'h1000_0000 + bus_s.mem_adr;

    inst_cache #(.LINES(LINES), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    inst_cache #(.LINES(LINES), .CNT_W(4)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_s.slave)
    );

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return 32'h1000_0000 + ((a / 4) * 4);
    endfunction

    function automatic int unsigned sat15(input int unsigned v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) begin
            mv[i] = 1'b0;
            mt[i] = 0;
        end
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic check_counters();
        check("hit_count",      32'(bus.hit_count),    m_hits);
        check("miss_count",     32'(bus.miss_count),   m_misses);
        check("hit_count_sat",  32'(bus_s.hit_count),  sat15(m_hits));
        check("miss_count_sat", 32'(bus_s.miss_count), sat15(m_misses));
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic fetch(input logic [31:0] a, input int waits, input bit scramble);
        int unsigned idx, tg, stall_cycles, beat, wait_ctr;
        bit          was_hit, upd_seen;
        logic [31:0] base;
        idx     = (a / 16) % LINES;
        tg      = a / (16 * LINES);
        base    = (a / 16) * 16;
        was_hit = mv[idx] && (mt[idx] == tg);
        adr     = a;
        ready   = 1'b0;
        @(negedge clk);
        check_counters();
        check("stall", 32'(bus.stall), 32'(!was_hit));
        check("mem_req_idle", 32'(bus.mem_req), 32'h0);
        if (was_hit) begin
            check("inst_hit", bus.inst, mem_fn(a));
            m_hits++;
        end else begin
            m_misses++;
            stall_cycles = 0;
            beat         = 0;
            wait_ctr     = 0;
            upd_seen     = 1'b0;
            for (int cyc = 0; cyc < LIMIT; cyc++) begin
                stall_cycles++;
                @(posedge clk);
                #1;
                if (beat < 4) begin
                    adr = scramble ? $urandom : a;
                    if (wait_ctr < waits) begin
                        ready = 1'b0;
                        wait_ctr++;
                    end else begin
                        ready    = 1'b1;
                        wait_ctr = 0;
                    end
                end else begin
                    ready = 1'($urandom_range(0, 1));
                    if (!upd_seen) begin
                        upd_seen = 1'b1;
                        adr      = scramble ? $urandom : a;
                    end else begin
                        adr = a;
                    end
                end
                @(negedge clk);
                if (!bus.stall) break;
                check("mem_req", 32'(bus.mem_req), 32'(beat < 4));
                if (beat < 4) begin
                    check("mem_adr", bus.mem_adr, base + beat * 4);
                    if (ready) beat++;
                end
            end
            check("penalty", stall_cycles, 6 + 4 * waits);
            check("beats", beat, 4);
            check("stall_after_fill", 32'(bus.stall), 32'h0);
            check("inst_after_fill", bus.inst, mem_fn(a));
            mv[idx] = 1'b1;
            mt[idx] = tg;
            m_hits++;
        end
        $display("[TB] fetch adr=%h waits=%0d scramble=%0d %s", a, waits, scramble,
                 was_hit ? "hit" : "miss");
        @(posedge clk);
        #1;
    endtask

    task automatic reset_mid_refill();
        adr   = 32'h80;
        ready = 1'b1;
        @(negedge clk);
        check("rmr_stall", 32'(bus.stall), 32'h1);
        repeat (3) @(posedge clk);
        #1;
        check("rmr_req_before", 32'(bus.mem_req), 32'h1);
        check("rmr_adr_before", bus.mem_adr, 32'h88);
        rst = 1'b1;
        #1;
        check("rmr_req_reset", 32'(bus.mem_req), 32'h0);
        check("rmr_adr_reset", bus.mem_adr, 32'h0);
        check("rmr_miss_reset", 32'(bus.miss_count), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        $display("[TB] reset asserted during refill of 0x80");
    endtask

    initial begin
        int unsigned ra;
        model_reset();
        @(negedge clk);
        check("reset_req", 32'(bus.mem_req), 32'h0);
        check("reset_adr", bus.mem_adr, 32'h0);
        check("reset_stall", 32'(bus.stall), 32'h1);
        check_counters();
        @(posedge clk);
        #1;
        rst = 1'b0;

        fetch(32'h0, 0, 1'b0);
        check("cold_miss_count", 32'(bus.miss_count), 32'h1);
        fetch(32'h4, 0, 1'b0);
        fetch(32'h8, 0, 1'b0);
        fetch(32'hC, 0, 1'b0);
        check("reuse_hit_count", 32'(bus.hit_count), 32'h4);

        fetch(32'h0, 0, 1'b0);
        fetch(32'h200, 0, 1'b0);
        fetch(32'h0, 0, 1'b0);
        check("conflict_miss_count", 32'(bus.miss_count), 32'h3);

        fetch(32'h40, 2, 1'b0);

        reset_mid_refill();
        fetch(32'h80, 0, 1'b0);
        fetch(32'h84, 1, 1'b0);

        for (int n = 0; n < 150; n++) begin
            ra = ($urandom_range(0, 2) << 9) | ($urandom_range(0, 7) << 4) | $urandom_range(0, 15);
            fetch(ra, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        for (int n = 0; n < 20; n++) begin
            fetch(32'h84, 0, 1'b0);
        end
        check("sat_hit_count", 32'(bus_s.hit_count), 32'hF);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
